// File: rtl/fpu_link_pkg.sv
//------------------------------------------------------------------------------
// fpu_link_pkg : shared constants and types for the FPU byte-link host.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fpu_link_pkg;

  localparam int FRAME_BYTES = 16;
  localparam int GAP_SLOTS   = 2;
  localparam int RES_BYTES   = 4;
  localparam int SLOT_LAST   = FRAME_BYTES + GAP_SLOTS - 1;
  localparam int FRAME_W     = 8 * FRAME_BYTES;
  localparam int RES_W       = 8 * RES_BYTES;

  localparam int SLOT_W = 5;
  localparam int RXC_W  = 3;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [RXC_W-1:0]  rxcnt_t;

  // Width-matched copies of the slot/count boundaries used in comparisons.
  localparam slot_t  SLOT_LAST_S  = slot_t'(SLOT_LAST);
  localparam slot_t  SLOT_FRAME_S = slot_t'(FRAME_BYTES);
  localparam slot_t  SLOT_SHIFT_S = slot_t'(FRAME_BYTES - 1);
  localparam rxcnt_t RX_FULL      = rxcnt_t'(RES_BYTES);
  localparam rxcnt_t RX_LAST      = rxcnt_t'(RES_BYTES - 1);

endpackage

`default_nettype wire

// File: rtl/fpu_link_host_if.sv
//------------------------------------------------------------------------------
// fpu_link_host_if : operand, byte-link and result signals of the link host.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fpu_link_host_if;
  import fpu_link_pkg::*;

  logic [FRAME_W-1:0] op_frame;
  logic               op_valid;
  logic               op_ready;
  logic [7:0]         tx_byte;
  logic               tx_busy;
  logic [7:0]         rx_byte;
  logic               rx_en;
  logic [RES_W-1:0]   res_data;
  logic               res_valid;
  logic               res_ready;
  logic               err_overrun;
  logic               err_short;
  logic               err_clr;

  // master: controller / accelerator side driving the host block.
  modport master (
    output op_frame, op_valid, rx_byte, rx_en, res_ready, err_clr,
    input  op_ready, tx_byte, tx_busy, res_data, res_valid, err_overrun, err_short
  );

  // slave: the link host itself.
  modport slave (
    input  op_frame, op_valid, rx_byte, rx_en, res_ready, err_clr,
    output op_ready, tx_byte, tx_busy, res_data, res_valid, err_overrun, err_short
  );

endinterface

`default_nettype wire

// File: rtl/fpu_link_rx.sv
//------------------------------------------------------------------------------
// fpu_link_rx : reassembles result words from enable-qualified byte bursts,
//               holds them in a 1-deep buffer and tracks sticky errors.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpu_link_rx
  import fpu_link_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_en,
  input  logic             res_ready,
  input  logic             err_clr,
  output logic [RES_W-1:0] res_data,
  output logic             res_valid,
  output logic             err_overrun,
  output logic             err_short
);

  logic             rx_en_d_q, rx_en_d_d;
  rxcnt_t           rx_cnt_q, rx_cnt_d;
  logic [RES_W-1:0] rx_sr_q, rx_sr_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             err_overrun_q, err_overrun_d;
  logic             err_short_q, err_short_d;

  logic             burst_end;
  logic             capture;
  logic             complete;
  logic [RES_W-1:0] word;

  // The first enable cycle carries a stale byte, hence the rx_en_d qualifier.
  assign burst_end = !rx_en && rx_en_d_q;
  assign capture   = rx_en && rx_en_d_q && (rx_cnt_q < RX_FULL);
  assign complete  = capture && (rx_cnt_q == RX_LAST);
  assign word      = {rx_sr_q[RES_W-9:0], rx_byte};

  always_comb begin
    rx_en_d_d     = rx_en;
    rx_cnt_d      = rx_cnt_q;
    rx_sr_d       = rx_sr_q;
    res_data_d    = res_data_q;
    res_valid_d   = res_valid_q;
    err_overrun_d = err_overrun_q;
    err_short_d   = err_short_q;

    if (burst_end) begin
      rx_cnt_d = '0;
    end else if (capture) begin
      rx_cnt_d = rx_cnt_q + rxcnt_t'(1);
    end

    if (capture) begin
      rx_sr_d = word;
    end

    if (res_ready) begin
      res_valid_d = 1'b0;
    end

    if (err_clr) begin
      err_overrun_d = 1'b0;
      err_short_d   = 1'b0;
    end

    if (complete) begin
      if (!res_valid_q || res_ready) begin
        res_data_d  = word;
        res_valid_d = 1'b1;
      end else begin
        err_overrun_d = 1'b1;
      end
    end

    if (burst_end && (rx_cnt_q < RX_FULL)) begin
      err_short_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_en_d_q     <= 1'b0;
      rx_cnt_q      <= '0;
      rx_sr_q       <= '0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      rx_en_d_q     <= rx_en_d_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_sr_q       <= rx_sr_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      err_overrun_q <= err_overrun_d;
      err_short_q   <= err_short_d;
    end
  end

  assign res_data    = res_data_q;
  assign res_valid   = res_valid_q;
  assign err_overrun = err_overrun_q;
  assign err_short   = err_short_q;

endmodule

`default_nettype wire

// File: rtl/fpu_link_host.sv
//------------------------------------------------------------------------------
// fpu_link_host : host peer of the FPU byte link; free-running TX slot framer
//                 plus the RX result reassembler.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpu_link_host
  import fpu_link_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fpu_link_host_if.slave bus
);

  slot_t              slot_q, slot_d;
  logic [FRAME_W-1:0] frame_sr_q, frame_sr_d;
  logic               real_q, real_d;
  logic               in_frame;

  // The slot counter never stalls so it stays locked to the accelerator's writer.
  always_comb begin
    slot_d     = (slot_q == SLOT_LAST_S) ? '0 : slot_q + slot_t'(1);
    frame_sr_d = frame_sr_q;
    real_d     = real_q;

    if (slot_q == SLOT_LAST_S) begin
      frame_sr_d = bus.op_valid ? bus.op_frame : '0;
      real_d     = bus.op_valid;
    end else if (slot_q < SLOT_SHIFT_S) begin
      frame_sr_d = {frame_sr_q[FRAME_W-9:0], 8'h00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= '0;
      frame_sr_q <= '0;
      real_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      frame_sr_q <= frame_sr_d;
      real_q     <= real_d;
    end
  end

  assign in_frame     = (slot_q < SLOT_FRAME_S);
  assign bus.op_ready = (slot_q == SLOT_LAST_S);
  assign bus.tx_byte  = in_frame ? frame_sr_q[FRAME_W-1 -: 8] : 8'h00;
  assign bus.tx_busy  = real_q && in_frame;

  fpu_link_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (bus.rx_byte),
    .rx_en       (bus.rx_en),
    .res_ready   (bus.res_ready),
    .err_clr     (bus.err_clr),
    .res_data    (bus.res_data),
    .res_valid   (bus.res_valid),
    .err_overrun (bus.err_overrun),
    .err_short   (bus.err_short)
  );

endmodule

`default_nettype wire

// File: tb/tb_fpu_link_host.sv
//------------------------------------------------------------------------------
// tb_fpu_link_host : directed self-checking bench for fpu_link_host.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fpu_link_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] FRAME_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  fpu_link_host_if bus ();

  fpu_link_host dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change on negedges; cycle 0 begins at the negedge that releases rst.
  task automatic apply_reset();
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_frame  = '0;
    bus.rx_en     = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.res_ready = 1'b0;
    bus.err_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stale byte cycle, then n bytes MSB first, then one idle cycle for burst end.
  task automatic send_burst(input logic [31:0] w, input int n, input logic rdy_last);
    logic [31:0] sh;
    sh          = w;
    bus.rx_en   = 1'b1;
    bus.rx_byte = 8'hEE;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.rx_byte   = sh[31:24];
      sh            = sh << 8;
      bus.res_ready = rdy_last && (i == n - 1);
      @(negedge clk);
    end
    bus.rx_en     = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.res_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_frame = FRAME_A;
    #1;
    checks++;
    if (bus.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", bus.tx_byte); end
    checks++;
    if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL reset_op_ready got %b want 0", bus.op_ready); end
    checks++;
    if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", bus.tx_busy); end
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== 32'h0) begin
      errors++; $display("FAIL reset_res got v=%b d=%h want v=0 d=00000000", bus.res_valid, bus.res_data);
    end
    checks++;
    if (bus.err_overrun !== 1'b0 || bus.err_short !== 1'b0) begin
      errors++; $display("FAIL reset_errs got ovr=%b sh=%b want 0 0", bus.err_overrun, bus.err_short);
    end
  endtask

  task automatic test_idle();
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (bus.tx_byte !== 8'h00 || bus.tx_busy !== 1'b0) begin
        errors++; $display("FAIL idle_tx c=%0d got byte=%h busy=%b want 00 0", c, bus.tx_byte, bus.tx_busy);
      end
      checks++;
      if (bus.op_ready !== (c == 17 || c == 35)) begin
        errors++; $display("FAIL idle_op_ready c=%0d got %b want %b", c, bus.op_ready, (c == 17 || c == 35));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tx_frame();
    logic [127:0] exp_f;
    logic [7:0]   exp_b;
    exp_f = FRAME_A;
    apply_reset();
    bus.op_valid = 1'b1;
    bus.op_frame = FRAME_A;
    for (int c = 0; c < 36; c++) begin
      exp_b = (c >= 18 && c <= 33) ? exp_f[127 - 8 * (c - 18) -: 8] : 8'h00;
      checks++;
      if (bus.tx_byte !== exp_b) begin
        errors++; $display("FAIL frame_tx_byte c=%0d got %h want %h", c, bus.tx_byte, exp_b);
      end
      checks++;
      if (bus.tx_busy !== (c >= 18 && c <= 33)) begin
        errors++; $display("FAIL frame_tx_busy c=%0d got %b want %b", c, bus.tx_busy, (c >= 18 && c <= 33));
      end
      checks++;
      if (bus.op_ready !== (c == 17 || c == 35)) begin
        errors++; $display("FAIL frame_op_ready c=%0d got %b want %b", c, bus.op_ready, (c == 17 || c == 35));
      end
      @(negedge clk);
      if (c == 17) bus.op_valid = 1'b0;
    end
  endtask

  task automatic test_rx_basic();
    apply_reset();
    send_burst(32'h40A00000, 4, 1'b0);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h40A00000) begin
      errors++; $display("FAIL rx_basic got v=%b d=%h want v=1 d=40a00000", bus.res_valid, bus.res_data);
    end
    checks++;
    if (bus.err_overrun !== 1'b0 || bus.err_short !== 1'b0) begin
      errors++; $display("FAIL rx_basic_errs got ovr=%b sh=%b want 0 0", bus.err_overrun, bus.err_short);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rx_pop got v=%b want 0", bus.res_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_burst(32'h3F800000, 4, 1'b0);
    send_burst(32'h40000000, 4, 1'b0);
    checks++;
    if (bus.res_data !== 32'h3F800000 || bus.res_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_keep got v=%b d=%h want v=1 d=3f800000", bus.res_valid, bus.res_data);
    end
    checks++;
    if (bus.err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", bus.err_overrun); end
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    checks++;
    if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b want 0", bus.err_overrun); end
    send_burst(32'h40000000, 4, 1'b1);
    checks++;
    if (bus.res_data !== 32'h40000000 || bus.res_valid !== 1'b1) begin
      errors++; $display("FAIL same_edge_take got v=%b d=%h want v=1 d=40000000", bus.res_valid, bus.res_data);
    end
    checks++;
    if (bus.err_overrun !== 1'b0) begin errors++; $display("FAIL same_edge_err got %b want 0", bus.err_overrun); end
  endtask

  task automatic test_short();
    apply_reset();
    send_burst(32'hDEAD0000, 2, 1'b0);
    checks++;
    if (bus.err_short !== 1'b1) begin errors++; $display("FAIL short_flag got %b want 1", bus.err_short); end
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL short_valid got %b want 0", bus.res_valid); end
    send_burst(32'hC0490FDB, 4, 1'b0);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'hC0490FDB) begin
      errors++; $display("FAIL short_next got v=%b d=%h want v=1 d=c0490fdb", bus.res_valid, bus.res_data);
    end
    checks++;
    if (bus.err_short !== 1'b1 || bus.err_overrun !== 1'b0) begin
      errors++; $display("FAIL short_sticky got sh=%b ovr=%b want 1 0", bus.err_short, bus.err_overrun);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.op_valid = 1'b1;
    bus.op_frame = FRAME_A;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (c == 17) bus.op_valid = 1'b0;
    end
    checks++;
    if (bus.tx_byte !== 8'h99 || bus.tx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre got byte=%h busy=%b want 99 1", bus.tx_byte, bus.tx_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.tx_byte !== 8'h00 || bus.tx_busy !== 1'b0) begin
      errors++; $display("FAIL mid_rst got byte=%h busy=%b want 00 0", bus.tx_byte, bus.tx_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (bus.op_ready !== (c == 17) || bus.tx_byte !== 8'h00) begin
        errors++; $display("FAIL mid_realign c=%0d got rdy=%b byte=%h want %b 00", c, bus.op_ready, bus.tx_byte, (c == 17));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_tx_frame();
    test_rx_basic();
    test_back_to_back();
    test_short();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_link_host.md
Name: fpu_link_host

Overview:
- Host-side peer of the FPU byte link, for driving the accelerator from an on-chip controller or test harness.
- TX half: serializes 128-bit operand frames ({I4,I3,I2,I1}) onto the 8-bit ui_in stream, in the fixed slot framing the accelerator's byte writer expects.
- RX half: reassembles 32-bit results from the accelerator's uo_out byte bursts, qualified by enable_output.
- Both halves are released from reset on the same edge as the accelerator.

Parameters:
- FRAME_BYTES, 16, bytes per operand frame; the first byte sent is frame[127:120].
- GAP_SLOTS, 2, idle byte slots after each frame while the writer hands off its data.
- RES_BYTES, 4, bytes per result burst; the first byte received is the MSB.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- op_frame  in  128  operands; [31:0]=I1, [63:32]=I2, [95:64]=I3, [127:96]=I4
- op_valid  in  1  operand frame pending
- op_ready  out  1  frame accepted this cycle when op_valid&op_ready
- tx_byte  out  8  to accelerator ui_in
- tx_busy  out  1  high during byte slots of a real (non-idle) frame
- rx_byte  in  8  from accelerator uo_out
- rx_en  in  1  from accelerator enable_output
- res_data  out  32  last assembled result
- res_valid  out  1  result pending
- res_ready  in  1  consumer accepts result
- err_overrun  out  1  sticky: result dropped because buffer was full
- err_short  out  1  sticky: rx_en fell before RES_BYTES bytes arrived
- err_clr  in  1  synchronous clear of both error flags

Behaviour:
- Reset (async, rst=1): slot=0, frame_sr=0, real_flag=0, rx_en_d=0, rx_cnt=0, rx_sr=0, res_data=0, res_valid=0, errors=0.
- After reset, tx_byte=0x00 and op_ready=0.
- TX timing:
  - Free-running slot counter runs 0..LAST, where LAST=FRAME_BYTES+GAP_SLOTS-1 (17); it wraps to 0 and never stalls.
  - tx_byte = frame_sr[127:120] when slot<FRAME_BYTES, else 0x00. It is driven from a register: no combinational path from op_* to tx_byte.
  - Edge ending slot s<FRAME_BYTES-1: frame_sr <= frame_sr<<8.
- TX load:
  - op_ready = (slot==LAST).
  - Edge ending LAST: frame_sr <= op_valid ? op_frame : 0, and real_flag <= op_valid.
  - With no op pending, an all-zero idle frame is sent; it yields no accelerator result.
- TX timing facts:
  - The first frame after reset is always idle.
  - Accept-to-first-byte latency is 1 cycle.
  - A new frame is accepted every 18 cycles at most.
  - tx_busy = real_flag && slot<FRAME_BYTES.
- TX reset mid-frame: the slot counter is forced to 0 with a zero frame, re-aligned with the accelerator, which is reset together with this block.
- RX capture:
  - rx_en_d <= rx_en every edge.
  - A byte is captured on an edge where rx_en=1 and rx_en_d=1, skipping the first enable cycle, which carries a stale byte.
  - Capture does rx_sr <= {rx_sr[23:0], rx_byte} and rx_cnt++.
  - rx_cnt saturates at RES_BYTES; extra bytes in the same burst are ignored.
- RX completion:
  - On the edge where rx_cnt goes 3→4, the word completes.
  - If res_valid=0, or res_ready=1 on that same edge: res_data <= assembled word and res_valid <= 1.
  - Otherwise the new word is dropped, res_data is kept, and err_overrun <= 1.
- RX burst end:
  - When rx_en=0 and rx_en_d=1: if rx_cnt<RES_BYTES, set err_short and discard the partial word.
  - In either case rx_cnt <= 0.
- RX handshake: res_valid clears on an edge with res_ready=1 unless a new word completes on that same edge.
- err_clr clears both flags; a same-edge error set wins.

Decomposition:
- Package fpu_link_pkg:
  - constants FRAME_BYTES, GAP_SLOTS, RES_BYTES, SLOT_LAST;
  - slot counter width (5b) and rx counter width (3b).
- Sub-module fpu_link_rx holds the RX capture, 1-deep result buffer and error flags. The TX slot sequencer stays in the top.

Test Plan:
- Idle after reset, op_valid=0 for 40 cycles -> tx_byte=0x00 throughout; op_ready pulses at cycles 17 and 35; tx_busy=0.
- op_frame=128'h00112233_44556677_8899AABB_CCDDEEFF, valid from reset -> accepted at cycle 17; tx_byte=00,11,…,FF in cycles 18..33, then 00,00; tx_busy high for cycles 18..33 only.
- rx_en high cycles 0..4, rx_byte=XX,40,A0,00,00 -> res_data=0x40A00000, res_valid=1 after edge ending cycle 4; no errors.
- Two back-to-back bursts (0x3F800000 then 0x40000000) with res_ready=0 -> res_data stays 0x3F800000; err_overrun=1; err_clr clears the flag. Repeat with res_ready=1 on the completion edge -> res_data=0x40000000, no error.
- rx_en high 3 cycles only -> err_short=1, res_valid stays 0; the next full burst assembles correctly.
- rst asserted at slot 9 of a real frame -> tx_byte=0 immediately; slot restarts at 0; op_ready next at cycle 17 after release.
